// File: rtl/fp_seq_pkg.sv
`default_nettype none
// ============================================================================
// fp_seq_pkg : shared types and constants for the FP16 adder keypad sequencer
// Revision   : 1.0 - initial release
// ============================================================================
package fp_seq_pkg;

  localparam int FP_W = 16;
  localparam logic [FP_W-1:0] ERR_DISP = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  localparam logic [1:0] LED_ENTER_A = 2'b00;
  localparam logic [1:0] LED_ENTER_B = 2'b01;
  localparam logic [1:0] LED_BUSY    = 2'b10;
  localparam logic [1:0] LED_END     = 2'b11;

  function automatic logic [1:0] led_of(state_t s);
    case (s)
      ST_ENTER_A:        return LED_ENTER_A;
      ST_ENTER_B:        return LED_ENTER_B;
      ST_ISSUE, ST_WAIT: return LED_BUSY;
      default:           return LED_END;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// fp_add_sequencer_if : key-event, adder and display bus of the sequencer
// Revision            : 1.0 - initial release
// ============================================================================
interface fp_add_sequencer_if;
  import fp_seq_pkg::*;

  logic            digit_valid;
  logic [3:0]      digit;
  logic            cmd_enter;
  logic            cmd_clear;
  logic [FP_W-1:0] op_a;
  logic [FP_W-1:0] op_b;
  logic            op_valid;
  logic [FP_W-1:0] res;
  logic            res_ovf;
  logic            res_unf;
  logic            res_valid;
  logic [FP_W-1:0] disp_val;
  logic [FP_W-1:0] result;
  logic [1:0]      flags;
  logic [1:0]      state_led;
  logic            err;

  // master: the sequencer itself
  modport master (
    input  digit_valid, digit, cmd_enter, cmd_clear,
    input  res, res_ovf, res_unf, res_valid,
    output op_a, op_b, op_valid, disp_val, result, flags, state_led, err
  );

  // slave: keypad decoder, adder and display side
  modport slave (
    output digit_valid, digit, cmd_enter, cmd_clear,
    output res, res_ovf, res_unf, res_valid,
    input  op_a, op_b, op_valid, disp_val, result, flags, state_led, err
  );

endinterface
`default_nettype wire

// File: rtl/fp_seq_operand_reg.sv
`default_nettype none
// ============================================================================
// fp_seq_operand_reg : MSB-first hex nibble shift register with digit counter
// Revision           : 1.0 - initial release
// ============================================================================
module fp_seq_operand_reg
  import fp_seq_pkg::*;
#(
  parameter int NDIG = 4,
  localparam int W   = 4 * NDIG,
  localparam int CW  = $clog2(NDIG + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [W-1:0]  load_val_i,
  input  logic [CW-1:0] load_cnt_i,
  input  logic          shift_i,
  input  logic [3:0]    digit_i,
  output logic [W-1:0]  val_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Once full, extra digits are dropped rather than shifting the MSB out.
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      val_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      val_d = load_val_i;
      cnt_d = load_cnt_i;
    end else if (shift_i && (cnt_q != CW'(NDIG))) begin
      val_d = {val_q[W-5:0], digit_i};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val_o = val_q;
  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fp_add_sequencer.sv
`default_nettype none
// ============================================================================
// fp_add_sequencer : keypad-driven issue/wait/latch controller for FP16 adder
// Optional feature : FP_SEQ_CHAIN_EN (enter in DONE chains result into A)
// Revision         : 1.0 - initial release
// ============================================================================
module fp_add_sequencer
  import fp_seq_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  fp_add_sequencer_if.master  bus
);

  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [FP_W-1:0] result_q;
  logic [1:0]      flags_q;

  logic [TW-1:0]   timer_inc;
  logic            key_clr, key_ent, key_dig;
  logic            in_end, chain_go;
  logic [FP_W-1:0] a_val, b_val, a_load_val;
  logic [CW-1:0]   a_cnt, b_cnt, a_load_cnt;
  logic            a_clr, a_load, a_shift;
  logic            b_clr, b_shift;

  // Only the highest-priority key event of a cycle acts.
  assign key_clr = bus.cmd_clear;
  assign key_ent = !bus.cmd_clear && bus.cmd_enter;
  assign key_dig = !bus.cmd_clear && !bus.cmd_enter && bus.digit_valid;

  assign in_end    = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign timer_inc = timer_q + TW'(1);

`ifdef FP_SEQ_CHAIN_EN
  assign chain_go = key_ent && (state_q == ST_DONE);
`else
  assign chain_go = 1'b0;
`endif

  assign a_clr      = key_clr && (state_q != ST_ENTER_B);
  assign a_shift    = key_dig && (state_q == ST_ENTER_A);
  assign a_load     = (key_dig && in_end) || chain_go;
  assign a_load_val = chain_go ? result_q : {{(FP_W-4){1'b0}}, bus.digit};
  assign a_load_cnt = chain_go ? CW'(NDIG) : CW'(1);

  assign b_clr   = (key_clr && (state_q != ST_ENTER_A))
                 || (key_ent && (state_q == ST_ENTER_A) && (a_cnt != '0))
                 || chain_go;
  assign b_shift = key_dig && (state_q == ST_ENTER_B);

  fp_seq_operand_reg #(.NDIG(NDIG)) u_opnd_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (a_clr),
    .load_i     (a_load),
    .load_val_i (a_load_val),
    .load_cnt_i (a_load_cnt),
    .shift_i    (a_shift),
    .digit_i    (bus.digit),
    .val_o      (a_val),
    .cnt_o      (a_cnt)
  );

  fp_seq_operand_reg #(.NDIG(NDIG)) u_opnd_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (b_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .load_cnt_i ('0),
    .shift_i    (b_shift),
    .digit_i    (bus.digit),
    .val_o      (b_val),
    .cnt_o      (b_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ENTER_A;
      timer_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        ST_ENTER_A: if (key_ent && (a_cnt != '0)) state_q <= ST_ENTER_B;
        ST_ENTER_B: if (key_ent && (b_cnt != '0)) state_q <= ST_ISSUE;
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= key_clr ? ST_ENTER_A : ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the last allowed cycle beats the timeout.
          if (key_clr) begin
            state_q <= ST_ENTER_A;
          end else if (bus.res_valid) begin
            state_q  <= ST_DONE;
            result_q <= bus.res;
            flags_q  <= {bus.res_ovf, bus.res_unf};
          end else if (timer_inc == TW'(TIMEOUT)) begin
            state_q <= ST_ERR;
          end else begin
            timer_q <= timer_inc;
          end
        end
        ST_DONE, ST_ERR: begin
          if (key_clr) begin
            state_q  <= ST_ENTER_A;
            result_q <= '0;
            flags_q  <= '0;
          end else if (key_dig) begin
            state_q <= ST_ENTER_A;
          end else if (chain_go) begin
            state_q <= ST_ENTER_B;
          end
        end
        default: state_q <= ST_ENTER_A;
      endcase
    end
  end

  always_comb begin
    bus.disp_val = a_val;
    case (state_q)
      ST_ENTER_A:                    bus.disp_val = a_val;
      ST_ENTER_B, ST_ISSUE, ST_WAIT: bus.disp_val = b_val;
      ST_DONE:                       bus.disp_val = result_q;
      ST_ERR:                        bus.disp_val = ERR_DISP;
      default:                       bus.disp_val = a_val;
    endcase
  end

  assign bus.op_a      = a_val;
  assign bus.op_b      = b_val;
  assign bus.op_valid  = (state_q == ST_ISSUE);
  assign bus.err       = (state_q == ST_ERR);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.state_led = led_of(state_q);

endmodule
`default_nettype wire

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
Keypad-driven controller that sequences the FP16 adder pipeline, replacing the manual S1 switch stepping. It assembles operand A and operand B from decoded hex-digit key events, then issues one add to the adder. It waits for the adder's result-valid, with a timeout, and latches the result and flags for display. It sits between the keypad decode path (key events) and the adder/7-segment display path.

Parameters:
NDIG, 4, hex digits per operand (operand width = 4*NDIG = 16)
TIMEOUT, 16, max cycles in WAIT before declaring error (>=1)

Ports:
clk  in  1  system clock (divided clock domain)
reset_n  in  1  asynchronous active-low reset
digit_valid  in  1  one-cycle pulse: new hex digit
digit  in  4  hex nibble, valid with digit_valid
cmd_enter  in  1  one-cycle pulse: commit current operand
cmd_clear  in  1  one-cycle pulse: clear / abort
op_a  out  16  operand A to adder
op_b  out  16  operand B to adder
op_valid  out  1  one-cycle issue strobe to adder
res  in  16  adder sum
res_ovf  in  1  adder overflow, valid with res_valid
res_unf  in  1  adder underflow, valid with res_valid
res_valid  in  1  adder result strobe
disp_val  out  16  value for 7-seg: operand being entered, or result
result  out  16  latched sum
flags  out  2  {ovf,unf} latched with result
state_led  out  2  00 entering A, 01 entering B, 10 busy (ISSUE/WAIT), 11 DONE/ERR
err  out  1  high in ERR

Behaviour:
- Reset is asynchronous and active-low (reset_n). Clock is clk; the block uses a single clock.
- On reset: state ENTER_A; op_a, op_b, result, disp_val = 0; flags = 0; op_valid = 0; err = 0; digit count = 0; timer = 0. Reset mid-WAIT drops op_valid and abandons the operation. A later res_valid is ignored, because the block is no longer in WAIT.
- States: ENTER_A, ENTER_B, ISSUE, WAIT, DONE, ERR.
- Input priority when events coincide: cmd_clear > cmd_enter > digit_valid. Only the highest-priority event acts.
- Digit entry (ENTER_A / ENTER_B):
  - A digit shifts in MSB-first: opnd <= {opnd[11:0], digit}, and count increments.
  - When count == NDIG, further digits are ignored (no wrap, no shift-out).
  - disp_val tracks the operand being entered, one cycle after the digit.
- cmd_enter in ENTER_A:
  - Ignored if count == 0.
  - Otherwise moves to ENTER_B with count = 0 and op_b = 0.
  - A short entry stays right-justified: "3C" gives 0x003C.
- cmd_enter in ENTER_B:
  - Ignored if count == 0.
  - Otherwise moves to ISSUE.
- ISSUE: op_valid = 1 for exactly one cycle. op_a and op_b are stable from ISSUE until DONE/ERR. Next state is WAIT with timer = 0.
- WAIT:
  - Timer increments each cycle.
  - res_valid → DONE next cycle, with result <= res and flags <= {res_ovf, res_unf}; disp_val = result.
  - res_valid on the same cycle the timer reaches TIMEOUT → DONE. Result wins over timeout.
  - Timer == TIMEOUT without res_valid → ERR, with err = 1 and disp_val = 16'hFFFF.
- Latency: enter in ENTER_B at cycle t → op_valid at t+1 → WAIT from t+2. res_valid at cycle w → result visible at w+1.
- DONE / ERR:
  - A digit starts a new operand A: count = 1, op_a = {12'b0, digit}, state ENTER_A, err cleared.
  - cmd_clear → ENTER_A with everything cleared.
  - cmd_enter → see Optional Feature.
- cmd_clear in ENTER_A / ENTER_B clears the current operand only, with count = 0; the state is kept.
- cmd_clear in ISSUE / WAIT aborts to ENTER_A and clears op_a, op_b. A late res_valid is ignored.
- Key events in ISSUE / WAIT other than clear are ignored.
- res_valid outside WAIT is ignored.

Optional Feature:
FP_SEQ_CHAIN_EN
- Defined: cmd_enter in DONE loads op_a <= result, sets count = NDIG and state ENTER_B, and clears op_b (running accumulation).
- Undefined: cmd_enter in DONE is ignored. In ERR, cmd_enter is always ignored.

Decomposition:
- Shared package fp_seq_pkg:
  - state enum (6 states)
  - state_led encodings
  - ERR_DISP = 16'hFFFF
  - FP16 width constant (16)
- One natural sub-module: fp_seq_operand_reg. It is the nibble shift register with digit counter, clear and load, instantiated for A and B.
- FSM and timer stay in the top module.

Test Plan:
- Digits 3,C,0,0, enter, 4,0,0,0, enter; adder model returns 0x4200 after 7 cycles → op_valid one pulse with op_a = 3C00, op_b = 4000; result = 4200, flags = 00, state_led = 11.
- Digits 3,C, enter → op_a = 003C, state ENTER_B; then enter with 0 digits → stays ENTER_B, no op_valid.
- Full add, adder never asserts res_valid → err = 1 exactly TIMEOUT (16) cycles after entering WAIT, disp_val = FFFF; then digit 1 → ENTER_A, op_a = 0001, err = 0.
- Five digits 1,2,3,4,5 → op_a = 1234. cmd_clear and digit 7 in the same cycle → op_a = 0000, count = 0.
- cmd_clear during WAIT, then res_valid with 0x5555 → state ENTER_A, result unchanged (0).
- With FP_SEQ_CHAIN_EN: after result 4200, enter, digits 3,C,0,0, enter → op_a = 4200, op_b = 3C00. Without it → enter ignored, state DONE.
